// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited imem requests and
// buffers returned words for IF/ID. Define FETCH_STAT_EN to add bubble/drop counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb,
  input  logic [31:0] jb_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic [31:0] inst
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] stat_bubble,
  output logic [31:0] stat_drop
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned SW  = CW + 2;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   pend_q [DEPTH];
  logic [PW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];
  logic [PW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [SW-1:0] inflight;
  logic          credit;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_take;
  logic          buf_push;
  logic          deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign inflight       = SW'(pend_cnt_q) + SW'(buf_cnt_q) + SW'(drop_q);
  assign credit         = inflight < SW'(DEPTH);
  assign imem_req_valid = !rst && !jb && credit;
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_q != '0);
  assign rsp_take       = imem_rsp_valid && (drop_q == '0) && (pend_cnt_q != '0);
  assign buf_push       = rsp_take && !jb;
  assign deq            = !stall && !jb && (buf_cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      pend_cnt_q <= '0;
      buf_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_cnt_q  <= '0;
      drop_q     <= '0;
    end else begin
      fpc_q      <= fpc_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      pend_cnt_q <= pend_cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_cnt_q  <= buf_cnt_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pend_q[pend_wr_q] <= fpc_q;
    end
    if (buf_push) begin
      buf_pc_q[buf_wr_q]   <= pend_q[pend_rd_q];
      buf_inst_q[buf_wr_q] <= imem_rsp_data;
    end
  end

  always_comb begin
    fpc_d      = fpc_q;
    pend_rd_d  = pend_rd_q;
    pend_wr_d  = pend_wr_q;
    pend_cnt_d = pend_cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_wr_d   = buf_wr_q;
    buf_cnt_d  = buf_cnt_q;
    drop_d     = drop_q;
    if (jb) begin
      fpc_d      = jb_target;
      pend_rd_d  = '0;
      pend_wr_d  = '0;
      pend_cnt_d = '0;
      buf_rd_d   = '0;
      buf_wr_d   = '0;
      buf_cnt_d  = '0;
      // Every still-pending word becomes owed; one arriving now is consumed on the spot.
      drop_d     = drop_q + pend_cnt_q - CW'(rsp_drop || rsp_take);
    end else begin
      if (req_fire) begin
        fpc_d     = fpc_q + 32'd4;
        pend_wr_d = ptr_inc(pend_wr_q);
      end
      if (rsp_take) begin
        pend_rd_d = ptr_inc(pend_rd_q);
        buf_wr_d  = ptr_inc(buf_wr_q);
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (deq) begin
        buf_rd_d = ptr_inc(buf_rd_q);
      end
      pend_cnt_d = pend_cnt_q + CW'(req_fire) - CW'(rsp_take);
      buf_cnt_d  = buf_cnt_q + CW'(rsp_take) - CW'(deq);
    end
  end

  always_comb begin
    pc   = '0;
    inst = NOP;
    if (buf_cnt_q != '0) begin
      pc   = buf_pc_q[buf_rd_q];
      inst = buf_inst_q[buf_rd_q];
    end
  end

`ifdef FETCH_STAT_EN
  logic [31:0] stat_bubble_q;
  logic [31:0] stat_drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bubble_q <= '0;
      stat_drop_q   <= '0;
    end else begin
      if ((buf_cnt_q == '0) && !stall) begin
        stat_bubble_q <= stat_bubble_q + 32'd1;
      end
      if (rsp_drop || (jb && rsp_take)) begin
        stat_drop_q <= stat_drop_q + 32'd1;
      end
    end
  end

  assign stat_bubble = stat_bubble_q;
  assign stat_drop   = stat_drop_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2) with a queued imem model and an in-order
// consumption monitor; expected PCs/words are computed locally.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jb;
  logic [31:0] jb_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc;
  logic [31:0] inst;
`ifdef FETCH_STAT_EN
  logic [31:0] stat_bubble;
  logic [31:0] stat_drop;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_consumed;
  logic [31:0] exp_pc;
  logic        rsp_en;
  logic [31:0] rq[$];
  logic [31:0] acc_log[$];
  logic [31:0] a0, a1;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .jb             (jb),
    .jb_target      (jb_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .inst           (inst)
`ifdef FETCH_STAT_EN
    ,
    .stat_bubble    (stat_bubble),
    .stat_drop      (stat_drop)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: consume/check the head at negedge, model imem accept and 1+ cycle response.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    if (!stall && !jb && (inst !== NOP)) begin
      check_eq("stream_pc", pc, exp_pc);
      check_eq("stream_inst", inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    if (acc) begin
      rq.push_back(a);
      acc_log.push_back(a);
    end
    #1;
    if (rsp_en && (rq.size() != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(rq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jb = 1'b0; jb_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    rsp_en = 1'b1; exp_pc = 32'h0; n_consumed = 0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_inst", inst, NOP);
`ifdef FETCH_STAT_EN
    check_eq("rst_stat_bubble", stat_bubble, 32'h0);
    check_eq("rst_stat_drop", stat_drop, 32'h0);
`endif

    // Streaming from reset with 1-cycle latency
    rst = 1'b0;
    #1;
    check_eq("t1_c0_valid", {31'b0, imem_req_valid}, 32'd1);
    check_eq("t1_c0_addr", imem_req_addr, 32'h0);
    check_eq("t1_c0_inst", inst, NOP);
    tick(); #1;
    check_eq("t1_c1_valid", {31'b0, imem_req_valid}, 32'd1);
    check_eq("t1_c1_addr", imem_req_addr, 32'h4);
    check_eq("t1_c1_inst", inst, NOP);
    tick(); #1;
    check_eq("t1_c2_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("t1_c2_pc", pc, 32'h0);
    check_eq("t1_c2_inst", inst, mem_word(32'h0));
    tick(); #1;
    check_eq("t1_c3_valid", {31'b0, imem_req_valid}, 32'd1);
    check_eq("t1_c3_addr", imem_req_addr, 32'h8);
    check_eq("t1_c3_pc", pc, 32'h4);
    ticks(10);
    check_eq("t1_count", n_consumed, 32'd8);
    check_eq("t1_next", exp_pc, 32'h20);

    // Stall with a full buffer
    stall = 1'b1;
    ticks(2);
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check_eq("t2_pc", pc, 32'h20);
      check_eq("t2_inst", inst, mem_word(32'h20));
      check_eq("t2_valid", {31'b0, imem_req_valid}, 32'd0);
      tick();
    end
    stall = 1'b0;
    ticks(6);
    check_eq("t2_count", n_consumed, 32'd12);
    check_eq("t2_next", exp_pc, 32'h30);

    // imem not ready: drain, then address must hold
    imem_req_ready = 1'b0;
    ticks(3);
    check_eq("t5_count", n_consumed, 32'd14);
    #1;
    check_eq("t5_bubble_inst", inst, NOP);
    for (int unsigned i = 0; i < 5; i++) begin
      #1;
      check_eq("t5_valid", {31'b0, imem_req_valid}, 32'd1);
      check_eq("t5_addr", imem_req_addr, 32'h38);
      tick();
    end

    // Two requests in flight, then redirect
    imem_req_ready = 1'b1; rsp_en = 1'b0;
    jb = 1'b1; jb_target = 32'h10;
    #1;
    check_eq("t3_jb_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    jb = 1'b0; exp_pc = 32'h10;
    #1;
    check_eq("t3_addr0", imem_req_addr, 32'h10);
    tick(); #1;
    check_eq("t3_addr1", imem_req_addr, 32'h14);
    check_eq("t3_valid1", {31'b0, imem_req_valid}, 32'd1);
    tick();
    jb = 1'b1; jb_target = 32'h100; rsp_en = 1'b1;
    #1;
    check_eq("t3_nocredit", {31'b0, imem_req_valid}, 32'd0);
    tick();
    jb = 1'b0; exp_pc = 32'h100;
    #1;
    check_eq("t3_owed_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("t3_owed_inst", inst, NOP);
    tick(); #1;
    check_eq("t3_tgt_valid", {31'b0, imem_req_valid}, 32'd1);
    check_eq("t3_tgt_addr", imem_req_addr, 32'h100);
    check_eq("t3_tgt_inst", inst, NOP);
    tick();
    ticks(4);
    check_eq("t3_count", n_consumed, 32'd16);
    check_eq("t3_next", exp_pc, 32'h108);

    // Redirect while stalled with a full buffer
    stall = 1'b1;
    tick(); #1;
    check_eq("t4_full_pc", pc, 32'h108);
    check_eq("t4_full_valid", {31'b0, imem_req_valid}, 32'd0);
    jb = 1'b1; jb_target = 32'h200;
    tick();
    jb = 1'b0; stall = 1'b0; exp_pc = 32'h200;
    #1;
    check_eq("t4_flush_pc", pc, 32'h0);
    check_eq("t4_flush_inst", inst, NOP);
    check_eq("t4_addr", imem_req_addr, 32'h200);
    ticks(4);
    check_eq("t4_count", n_consumed, 32'd18);

    // Redirect to the top word: address wraps to zero
    imem_req_ready = 1'b0;
    ticks(3);
    check_eq("t6_drain", n_consumed, 32'd19);
    imem_req_ready = 1'b1; jb = 1'b1; jb_target = 32'hFFFF_FFFC;
    acc_log.delete();
    #1;
    check_eq("t6_jb_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    jb = 1'b0; exp_pc = 32'hFFFF_FFFC;
    ticks(7);
    a0 = (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF;
    a1 = (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF;
    check_eq("t6_acc_n", acc_log.size(), 32'd5);
    check_eq("t6_acc0", a0, 32'hFFFF_FFFC);
    check_eq("t6_acc1", a1, 32'h0000_0000);
    check_eq("t6_count", n_consumed, 32'd23);
    check_eq("t6_next", exp_pc, 32'h0000_000C);
`ifdef FETCH_STAT_EN
    check_eq("stat_drop", stat_drop, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
